layer_sequencer: RTL and testbench

- Top-level scheduler for the inference pipeline. It runs the N layer engines (conv / full_connect1 / full_connect2 ...) strictly one after another, each under its own ena / iRst_n / done handshake.
- Owns the single weight-ROM address port and the single shared MultAdder. It grants both to exactly one layer at a time and muxes that layer's buses through.
- Adds a per-layer watchdog so that a hung layer (for example, one stalled waiting on a zero ROM word) is reported rather than locking the board.

---
 rtl/nn_pkg.sv | 22 ++
 rtl/bus_onehot_mux.sv | 24 ++
 rtl/layer_sequencer.sv | 131 +++++++++++++
 tb/tb_layer_sequencer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and default dimensions for the inference pipeline.
// Used by the layer sequencer and the layer engines it schedules.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_FAULT   = 3'd4
    } seq_state_e;

    localparam int DEF_BIT    = 16;
    localparam int DEF_LANES  = 128;
    localparam int DEF_ADDR_W = 11;

    // Weight-ROM base address of each layer's coefficient block.
    localparam logic [10:0] ROM_BASE_CONV = 11'h000;
    localparam logic [10:0] ROM_BASE_FC1  = 11'h100;
    localparam logic [10:0] ROM_BASE_FC2  = 11'h500;

endpackage

// File: rtl/bus_onehot_mux.sv
// One-hot AND-OR bus multiplexer; an all-zero select yields an all-zero bus,
// so shared buses never float.
module bus_onehot_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 2
) (
    input  logic [N-1:0]       sel,
    input  logic [N*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   dout
);

    // OR together every input slice whose select bit is set.
    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) begin
            if (sel[k]) begin
                dout = dout | din[k*WIDTH +: WIDTH];
            end else begin
                dout = dout;
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Runs the layer engines one after another, grants the ROM port and the
// shared MultAdder to the active layer, and flags a hung layer via a watchdog.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int BIT      = DEF_BIT,
    parameter int LANES    = DEF_LANES,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TIMEOUT  = 1048576,
    parameter int IDX_W    = 2
) (
    input  logic                            clk,
    input  logic                            iRst,
    input  logic                            iStart,
    input  logic [N_LAYERS-1:0]             iLayerDone,
    input  logic [N_LAYERS*ADDR_W-1:0]      iLayerAddr,
    input  logic [N_LAYERS*LANES*BIT-1:0]   iLayerOpr1,
    input  logic [N_LAYERS*LANES*BIT-1:0]   iLayerOpr2,
    output logic [N_LAYERS-1:0]             oLayerEna,
    output logic [N_LAYERS-1:0]             oLayerRst_n,
    output logic [ADDR_W-1:0]               oRomAddr,
    output logic [LANES*BIT-1:0]            oOpr1,
    output logic [LANES*BIT-1:0]            oOpr2,
    output logic [IDX_W-1:0]                oCurLayer,
    output logic                            oBusy,
    output logic                            oDone,
    output logic                            oErr
);

    localparam int                OPR_W    = LANES * BIT;
    localparam int                WD_W     = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_MAX   = {WD_W{1'b1}};
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_LAYERS - 1);

    seq_state_e      state_r;
    logic [WD_W-1:0] wd_r;

    function automatic logic [N_LAYERS-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot = {{(N_LAYERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Sequencing FSM; every control output is a register updated here.
    always_ff @(posedge clk or posedge iRst) begin
        if (iRst) begin
            state_r     <= S_IDLE;
            wd_r        <= '0;
            oCurLayer   <= '0;
            oLayerEna   <= '0;
            oLayerRst_n <= '1;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oErr        <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_FAULT: begin
                    if (iStart) begin
                        oCurLayer   <= '0;
                        oLayerEna   <= onehot('0);
                        oLayerRst_n <= ~onehot('0);
                        oBusy       <= 1'b1;
                        oDone       <= 1'b0;
                        oErr        <= 1'b0;
                        state_r     <= S_CLEAR;
                    end else begin
                        state_r     <= state_r;
                    end
                end
                S_CLEAR: begin
                    // Layer has seen ena with reset low for one cycle; let it run.
                    oLayerRst_n <= '1;
                    wd_r        <= '0;
                    state_r     <= S_RUN;
                end
                S_RUN: begin
                    if (iLayerDone[oCurLayer]) begin
                        oLayerEna <= '0;
                        state_r   <= S_RELEASE;
                    end else if (wd_r == WD_LIMIT) begin
                        oLayerEna <= '0;
                        oBusy     <= 1'b0;
                        oErr      <= 1'b1;
                        state_r   <= S_FAULT;
                    end else if (wd_r != WD_MAX) begin
                        wd_r      <= wd_r + WD_W'(1);
                    end else begin
                        wd_r      <= wd_r;
                    end
                end
                S_RELEASE: begin
                    if (oCurLayer == LAST_IDX) begin
                        oDone       <= 1'b1;
                        oBusy       <= 1'b0;
                        state_r     <= S_IDLE;
                    end else begin
                        oCurLayer   <= oCurLayer + IDX_W'(1);
                        oLayerEna   <= onehot(oCurLayer + IDX_W'(1));
                        oLayerRst_n <= ~onehot(oCurLayer + IDX_W'(1));
                        state_r     <= S_CLEAR;
                    end
                end
                default: begin
                    oLayerEna   <= '0;
                    oLayerRst_n <= '1;
                    oBusy       <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    bus_onehot_mux #(.WIDTH(ADDR_W), .N(N_LAYERS)) u_addr_mux (
        .sel  (oLayerEna),
        .din  (iLayerAddr),
        .dout (oRomAddr)
    );

    bus_onehot_mux #(.WIDTH(OPR_W), .N(N_LAYERS)) u_opr1_mux (
        .sel  (oLayerEna),
        .din  (iLayerOpr1),
        .dout (oOpr1)
    );

    bus_onehot_mux #(.WIDTH(OPR_W), .N(N_LAYERS)) u_opr2_mux (
        .sel  (oLayerEna),
        .din  (iLayerOpr2),
        .dout (oOpr2)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised bench for layer_sequencer: responsive layer models, a schedule-based
// reference model checked every cycle, and literal pins on the key timings.
module tb_layer_sequencer;

    localparam int NL = 3;
    localparam int BW = 16;
    localparam int LN = 4;
    localparam int AW = 11;
    localparam int TO = 64;
    localparam int OW = LN * BW;

    logic             clk;
    logic             iRst;
    logic             iStart;
    logic [NL-1:0]    iLayerDone;
    logic [NL*AW-1:0] iLayerAddr;
    logic [NL*OW-1:0] iLayerOpr1;
    logic [NL*OW-1:0] iLayerOpr2;
    logic [NL-1:0]    oLayerEna;
    logic [NL-1:0]    oLayerRst_n;
    logic [AW-1:0]    oRomAddr;
    logic [OW-1:0]    oOpr1;
    logic [OW-1:0]    oOpr2;
    logic [1:0]       oCurLayer;
    logic             oBusy;
    logic             oDone;
    logic             oErr;

    layer_sequencer #(
        .N_LAYERS(NL), .BIT(BW), .LANES(LN), .ADDR_W(AW), .TIMEOUT(TO), .IDX_W(2)
    ) dut (
        .clk(clk), .iRst(iRst), .iStart(iStart), .iLayerDone(iLayerDone),
        .iLayerAddr(iLayerAddr), .iLayerOpr1(iLayerOpr1), .iLayerOpr2(iLayerOpr2),
        .oLayerEna(oLayerEna), .oLayerRst_n(oLayerRst_n), .oRomAddr(oRomAddr),
        .oOpr1(oOpr1), .oOpr2(oOpr2), .oCurLayer(oCurLayer), .oBusy(oBusy),
        .oDone(oDone), .oErr(oErr)
    );

    int            vecs = 0;
    int            miscompares = 0;
    int            dur [NL];          // 0 = layer never finishes
    int            lc  [NL];
    logic [NL-1:0] ld;
    logic [NL-1:0] spur;
    logic [AW-1:0] la  [NL];
    logic [OW-1:0] o1v [NL];
    logic [OW-1:0] o2v [NL];
    bit            rst_seen = 1'b0;

    // model state
    bit            started = 1'b0;
    int            s_cyc = 0;
    int            cyc = 0;
    int            sd [NL];
    logic          exp_busy_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign iLayerDone = ld | spur;
    always_comb begin
        for (int k = 0; k < NL; k++) begin
            iLayerAddr[k*AW +: AW] = la[k];
            iLayerOpr1[k*OW +: OW] = o1v[k];
            iLayerOpr2[k*OW +: OW] = o2v[k];
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected outputs t cycles after the start edge, from the layer schedule:
    // CLEAR at base, RUN for min(d,TO) cycles, then RELEASE, next base = base+d+2.
    task automatic eval(input int t, output logic [NL-1:0] e_ena, output logic [NL-1:0] e_rstn,
                        output logic e_busy, output logic e_done, output logic e_err,
                        output logic [1:0] e_cur, output int g);
        int base;
        int dk;
        base = 0;
        e_ena = '0; e_rstn = '1; e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_cur = 2'd0; g = -1;
        if (!started) return;
        for (int k = 0; k < NL; k++) begin
            dk = (sd[k] == 0) ? 100000 : sd[k];
            e_cur = 2'(k);
            if (t == base) begin
                e_ena = 3'(1 << k); e_rstn = ~e_ena; e_busy = 1'b1; g = k; return;
            end
            if (t > base && t <= base + ((dk > TO) ? TO : dk)) begin
                e_ena = 3'(1 << k); e_busy = 1'b1; g = k; return;
            end
            if (dk > TO) begin
                e_err = 1'b1; return;
            end
            if (t == base + dk + 1) begin
                e_busy = 1'b1; return;
            end
            base += dk + 2;
        end
        e_done = 1'b1;
    endtask

    // Layer engine models: count cycles with ena high and rst_n high, raise done after dur.
    initial begin
        ld = '0;
        for (int k = 0; k < NL; k++) lc[k] = 0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NL; k++) begin
                if (!oLayerEna[k] || !oLayerRst_n[k]) begin
                    lc[k] = 0; ld[k] = 1'b0;
                end else begin
                    lc[k] = lc[k] + 1;
                    if (dur[k] != 0 && lc[k] >= dur[k]) ld[k] = 1'b1;
                end
            end
        end
    end

    // Compare process: track starts at the clock edge, check every output mid-cycle.
    initial begin
        logic [NL-1:0] e_ena, e_rstn;
        logic          e_busy, e_done, e_err;
        logic [1:0]    e_cur;
        int            g;
        forever begin
            @(posedge clk);
            cyc++;
            if (!iRst && iStart && !exp_busy_prev) begin
                started = 1'b1;
                s_cyc = cyc;
                for (int k = 0; k < NL; k++) sd[k] = dur[k];
            end
            @(negedge clk);
            if (iRst || rst_seen) begin
                started = 1'b0;
                rst_seen = 1'b0;
            end
            eval(cyc - s_cyc, e_ena, e_rstn, e_busy, e_done, e_err, e_cur, g);
            exp_busy_prev = e_busy;
            check("ena",   64'(oLayerEna),   64'(e_ena));
            check("rst_n", 64'(oLayerRst_n), 64'(e_rstn));
            check("busy",  64'(oBusy),       64'(e_busy));
            check("done",  64'(oDone),       64'(e_done));
            check("err",   64'(oErr),        64'(e_err));
            check("cur",   64'(oCurLayer),   64'(e_cur));
            check("rom",   64'(oRomAddr),    (g >= 0) ? 64'(la[g])  : 64'h0);
            check("opr1",  64'(oOpr1),       (g >= 0) ? 64'(o1v[g]) : 64'h0);
            check("opr2",  64'(oOpr2),       (g >= 0) ? 64'(o2v[g]) : 64'h0);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 iStart = 1'b1;
        @(posedge clk); #2 iStart = 1'b0;
    endtask

    // Poll a flag (0 = oDone, 1 = oErr) starting at cycle offset 'from'; n is the offset seen.
    task automatic wait_for(input int which, input int from, output int n);
        for (n = from; n < from + 400; n++) begin
            @(negedge clk);
            if ((which == 0) ? oDone : oErr) break;
        end
    endtask

    task automatic set_dur(input int d0, input int d1, input int d2);
        @(posedge clk); #2;
        dur[0] = d0; dur[1] = d1; dur[2] = d2;
    endtask

    initial begin
        int n;
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        iRst = 1'b1; iStart = 1'b0; spur = '0;
        dur[0] = 10; dur[1] = 20; dur[2] = 5;
        la[0] = 11'h011; la[1] = 11'h222; la[2] = 11'h333;
        for (int k = 0; k < NL; k++) begin
            o1v[k] = {$urandom, $urandom};
            o2v[k] = {$urandom, $urandom};
        end
        repeat (3) @(negedge clk);
        check("rst_ena",   64'(oLayerEna),   64'h0);
        check("rst_rst_n", 64'(oLayerRst_n), 64'h7);
        check("rst_rom",   64'(oRomAddr),    64'h0);
        @(posedge clk); #2 iRst = 1'b0;
        repeat (2) @(posedge clk);

        // nominal: 10/20/5
        pulse_start();
        @(negedge clk);
        check("start_ena", 64'(oLayerEna), 64'h1);
        repeat (11) @(negedge clk);                 // t = 11, RELEASE of layer 0
        check("rel_rom", 64'(oRomAddr), 64'h0);
        repeat (9) @(negedge clk);                  // t = 20, layer 1 running
        check("run1_rom", 64'(oRomAddr),  64'h222);
        check("run1_ena", 64'(oLayerEna), 64'h2);
        wait_for(0, 21, n);
        check("nom_done_t", 64'(n), 64'd41);
        check("nom_busy",   64'(oBusy), 64'h0);

        // spurious start and foreign done while layer 0 runs
        pulse_start();
        repeat (3) @(negedge clk);
        spur = 3'b100; iStart = 1'b1;
        @(negedge clk); iStart = 1'b0;
        repeat (3) @(negedge clk);
        spur = '0;
        wait_for(0, 7, n);
        check("spur_done_t", 64'(n), 64'd41);

        // watchdog: layer 1 hangs
        set_dur(10, 0, 5);
        pulse_start();
        wait_for(1, 0, n);
        check("wd_err_t", 64'(n), 64'd77);
        check("wd_ena",   64'(oLayerEna), 64'h0);
        set_dur(10, 20, 5);
        pulse_start();
        @(negedge clk);
        check("restart_err", 64'(oErr),      64'h0);
        check("restart_ena", 64'(oLayerEna), 64'h1);
        wait_for(0, 1, n);
        check("restart_done_t", 64'(n), 64'd41);

        // done coincides with the last watchdog count
        set_dur(64, 3, 3);
        pulse_start();
        wait_for(0, 0, n);
        check("coll_done_t", 64'(n),    64'd76);
        check("coll_err",    64'(oErr), 64'h0);
        set_dur(65, 3, 3);
        pulse_start();
        wait_for(1, 0, n);
        check("wd65_err_t", 64'(n), 64'd65);

        // asynchronous reset during layer 1
        set_dur(10, 20, 5);
        pulse_start();
        repeat (16) @(negedge clk);
        @(posedge clk); #2 rst_seen = 1'b1; iRst = 1'b1;
        #1;
        check("arst_ena",  64'(oLayerEna), 64'h0);
        check("arst_busy", 64'(oBusy),     64'h0);
        check("arst_done", 64'(oDone),     64'h0);
        #1 iRst = 1'b0;

        // randomised traffic
        for (int blk = 0; blk < 8; blk++) begin
            iStart = 1'b0;
            for (n = 0; n < 400; n++) begin
                @(negedge clk);
                if (!oBusy) break;
            end
            check("idle_wait", 64'(n < 400), 64'h1);
            set_dur($urandom_range(1, 70), $urandom_range(1, 70), $urandom_range(1, 70));
            for (int c = 0; c < 200; c++) begin
                @(posedge clk); #2;
                iStart = ($urandom_range(0, 15) == 0);
                for (int k = 0; k < NL; k++) begin
                    la[k]  = AW'($urandom);
                    o1v[k] = {$urandom, $urandom};
                    o2v[k] = {$urandom, $urandom};
                end
            end
        end
        iStart = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
